// File: rtl/alu_mp_sequencer.sv
// ---------------------------------------------------------------------------
// alu_mp_sequencer
//   Multi-precision add/subtract sequencer placed in front of a combinational
//   WIDTH-bit ALU. Operands of WIDTH*LIMBS bits are sent through the ALU one
//   limb per clock, least significant limb first. The ALU carry (alu_y[WIDTH])
//   is chained into the next limb by picking the carry-in variant of the
//   select code.
//
// Ports
//   clk, reset_n   clock (rising edge) / asynchronous active-low reset
//   start          request, accepted only in IDLE
//   op_sub         0: a+b, 1: a-b (computed as a + ~b + 1)
//   op_a, op_b     operands, sampled when start is accepted
//   busy           high in RUN and DONE
//   done           one-cycle pulse, result/carry_out valid
//   result         sum/difference, held until the next accepted start
//   carry_out      final carry (subtract: 1 = no borrow)
//   alu_a, alu_b   limb operands to the ALU
//   alu_select     ALU function code
//   alu_y          ALU result, [WIDTH] is the carry
// ---------------------------------------------------------------------------
module alu_mp_sequencer #(
    parameter int WIDTH = 8,
    parameter int LIMBS = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   op_sub,
    input  logic [WIDTH*LIMBS-1:0] op_a,
    input  logic [WIDTH*LIMBS-1:0] op_b,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH*LIMBS-1:0] result,
    output logic                   carry_out,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [2:0]             alu_select,
    input  logic [WIDTH:0]         alu_y
);

    localparam int OPW = WIDTH * LIMBS;
    localparam int CW  = (LIMBS > 2) ? $clog2(LIMBS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LIMBS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            sub_q, sub_d;
    logic [OPW-1:0]  a_q, a_d;
    logic [OPW-1:0]  b_q, b_d;
    logic [OPW-1:0]  res_q, res_d;
    logic            cout_q, cout_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        sub_d      = sub_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        cout_d     = cout_q;
        alu_a      = '0;
        alu_b      = '0;
        alu_select = 3'b000;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    sub_d   = op_sub;
                    cnt_d   = '0;
                    // Subtract starts with carry-in 1 to form the two's complement of b.
                    carry_d = op_sub;
                    state_d = RUN;
                end
            end
            RUN: begin
                alu_a = a_q[WIDTH-1:0];
                alu_b = b_q[WIDTH-1:0];
                if (sub_q) alu_select = carry_q ? 3'b101 : 3'b100;
                else       alu_select = carry_q ? 3'b011 : 3'b010;

                // Result fills from the top so that after LIMBS shifts limb 0 lands at the bottom.
                res_d   = {alu_y[WIDTH-1:0], res_q[OPW-1:WIDTH]};
                a_d     = a_q >> WIDTH;
                b_d     = b_q >> WIDTH;
                carry_d = alu_y[WIDTH];
                if (cnt_q == CNT_LAST) begin
                    cout_d  = alu_y[WIDTH];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign result    = res_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_alu_mp_sequencer.sv
module tb_alu_mp_sequencer;

    localparam int WIDTH = 8;
    localparam int LIMBS = 4;
    localparam int OPW   = WIDTH * LIMBS;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic            op_sub = 1'b0;
    logic [OPW-1:0]  op_a = '0;
    logic [OPW-1:0]  op_b = '0;
    logic            busy, done, carry_out;
    logic [OPW-1:0]  result;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [2:0]      alu_select;
    logic [WIDTH:0]  alu_y;

    int n_assert = 0;
    int n_fail   = 0;

    // Run-time trace of the last operation
    logic [11:0] sel_trace;
    int          lat;
    logic        busy_all;

    always #5 clk = ~clk;

    // Combinational ALU behaviour for the codes the sequencer uses
    always_comb begin
        case (alu_select)
            3'b010:  alu_y = {1'b0, alu_a} + {1'b0, alu_b};
            3'b011:  alu_y = {1'b0, alu_a} + {1'b0, alu_b} + 9'd1;
            3'b100:  alu_y = {1'b0, alu_a} + {1'b0, ~alu_b};
            3'b101:  alu_y = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
            default: alu_y = '0;
        endcase
    end

    alu_mp_sequencer #(.WIDTH(WIDTH), .LIMBS(LIMBS)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op_sub(op_sub),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .result(result), .carry_out(carry_out),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_y(alu_y)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op at a negedge and follow it until done (bounded). Returns at
    // the negedge of the done cycle.
    task automatic do_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic sub);
        op_a = a; op_b = b; op_sub = sub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        sel_trace = '0;
        busy_all = 1'b1;
        while (!done && lat < 20) begin
            if (!busy) busy_all = 1'b0;
            if (lat <= LIMBS) sel_trace = {sel_trace[8:0], alu_select};
            @(negedge clk);
            lat++;
        end
        if (!busy) busy_all = 1'b0;
    endtask

    function automatic logic [OPW:0] model(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                           input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + 33'd1;
        return {1'b0, a} + {1'b0, b};
    endfunction

    initial begin
        logic [OPW-1:0] ra, rb;
        logic           rs;
        int             dcount;

        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", carry_out, 0);
        chk("rst_alu", {alu_a, alu_b, alu_select}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // add 0x1FF + 1: carry chains from limb 0 into limb 1
        do_op(32'h0000_01FF, 32'h0000_0001, 1'b0);
        chk("add1_sel_trace", sel_trace, {3'b010, 3'b011, 3'b010, 3'b010});
        chk("add1_latency", lat, LIMBS + 1);
        chk("add1_busy", busy_all, 1);
        chk("add1_result", result, 32'h0000_0200);
        chk("add1_cout", carry_out, 0);
        @(negedge clk);
        chk("add1_done_once", done, 0);
        chk("add1_idle", busy, 0);

        // add overflow wraps
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        chk("add2_res_cout", {carry_out, result}, {1'b1, 32'h0000_0000});
        @(negedge clk);

        // sub without borrow
        do_op(32'h0000_0100, 32'h0000_0001, 1'b1);
        chk("sub1_first_sel", sel_trace[11:9], 3'b101);
        chk("sub1_res_cout", {carry_out, result}, {1'b1, 32'h0000_00FF});
        @(negedge clk);

        // sub with borrow
        do_op(32'h0000_0000, 32'h0000_0001, 1'b1);
        chk("sub2_res_cout", {carry_out, result}, {1'b0, 32'hFFFF_FFFF});
        @(negedge clk);

        // start while busy is ignored
        op_a = 32'h1111_1111; op_b = 32'h2222_2222; op_sub = 1'b0; start = 1'b1;
        @(negedge clk);            // RUN cycle 1
        start = 1'b0;
        @(negedge clk);            // RUN cycle 2
        op_a = 32'h5555_5555; op_b = 32'h0101_0101; op_sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcount = 0;
        while (!done && dcount < 10) begin @(negedge clk); dcount++; end
        chk("ign_done_seen", done, 1);
        start = 1'b1;              // pulse during DONE
        @(negedge clk);
        start = 1'b0;
        chk("ign_result", {carry_out, result}, {1'b0, 32'h3333_3333});
        chk("ign_not_queued", busy, 0);
        @(negedge clk);
        chk("ign_still_idle", busy, 0);

        // reset during 2nd RUN cycle
        op_a = 32'h0000_1234; op_b = 32'h0000_4321; op_sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);            // 2nd RUN cycle
        reset_n = 1'b0;
        #1;
        chk("arst_state", {busy, done, alu_select}, 0);
        chk("arst_result", result, 0);
        @(negedge clk);
        reset_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        chk("arst_no_done", dcount, 0);
        do_op(32'd5, 32'd7, 1'b0);
        chk("arst_after_add", result, 32'h0000_000C);
        @(negedge clk);

        // random back-to-back ops
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            if (i % 50 == 0) rb = ra;
            do_op(ra, rb, rs);
            chk($sformatf("rand%0d", i), {carry_out, result}, model(ra, rb, rs));
            if (i % 100 == 0) chk($sformatf("rand%0d_lat", i), lat, LIMBS + 1);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
